// File: rtl/cmpl_mult_arbiter.sv
// -----------------------------------------------------------------------------
// cmpl_mult_arbiter
//   Shares one external registered complex multiplier among NUM_REQ requesters.
//   A round-robin arbiter picks at most one requester per cycle and drives its
//   operands to the multiplier. An ID tag pipeline matched to MULT_LATENCY
//   tracks each issue, and the multiplier result is captured with its tag into
//   a first-word-fall-through result FIFO. Issue is credit-controlled against
//   FIFO space, so a result can never arrive at a full FIFO even though the
//   multiplier itself cannot stall.
//
// Ports
//   i_clock           system clock, rising edge
//   i_rst_n           asynchronous active-low reset
//   i_req_valid       per-requester operand valid
//   o_req_ready       one-hot grant (or zero); handshake = valid & ready
//   i_req_a_real/imag flattened operand A, requester i at [i*W +: W]
//   i_req_b_real/imag flattened operand B, same layout
//   o_mult_a/b_*      operands to the multiplier (zero when nothing issues)
//   i_mult_res_*      multiplier result, MULT_LATENCY edges after sampling
//   o_res_valid       FIFO head valid
//   i_res_ready       consumer accepts head
//   o_res_id          requester index of head result
//   o_res_real/imag   head result, CPLX_WIDTH signed
// -----------------------------------------------------------------------------
module cmpl_mult_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int REAL_WIDTH   = 18,
   parameter int IMGN_WIDTH   = 18,
   parameter int MULT_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4,
   localparam int CPLX_WIDTH  = REAL_WIDTH + IMGN_WIDTH,
   localparam int ID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                            i_clock,
   input  logic                            i_rst_n,
   input  logic [NUM_REQ-1:0]              i_req_valid,
   output logic [NUM_REQ-1:0]              o_req_ready,
   input  logic [NUM_REQ*REAL_WIDTH-1:0]   i_req_a_real,
   input  logic [NUM_REQ*IMGN_WIDTH-1:0]   i_req_a_imag,
   input  logic [NUM_REQ*REAL_WIDTH-1:0]   i_req_b_real,
   input  logic [NUM_REQ*IMGN_WIDTH-1:0]   i_req_b_imag,
   output logic [REAL_WIDTH-1:0]           o_mult_a_real,
   output logic [IMGN_WIDTH-1:0]           o_mult_a_imag,
   output logic [REAL_WIDTH-1:0]           o_mult_b_real,
   output logic [IMGN_WIDTH-1:0]           o_mult_b_imag,
   input  logic [CPLX_WIDTH-1:0]           i_mult_res_real,
   input  logic [CPLX_WIDTH-1:0]           i_mult_res_imag,
   output logic                            o_res_valid,
   input  logic                            i_res_ready,
   output logic [ID_WIDTH-1:0]             o_res_id,
   output logic [CPLX_WIDTH-1:0]           o_res_real,
   output logic [CPLX_WIDTH-1:0]           o_res_imag
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   // ---------------------------------------------------------------- state
   logic [ID_WIDTH-1:0]   r_rr_ptr;
   logic [CNT_W-1:0]      r_credits;
   logic                  r_tag_vld [MULT_LATENCY];
   logic [ID_WIDTH-1:0]   r_tag_id  [MULT_LATENCY];

   logic [ID_WIDTH-1:0]   r_mem_id   [FIFO_DEPTH];
   logic [CPLX_WIDTH-1:0] r_mem_real [FIFO_DEPTH];
   logic [CPLX_WIDTH-1:0] r_mem_imag [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   logic                  r_res_valid;
   logic [ID_WIDTH-1:0]   r_res_id;
   logic [CPLX_WIDTH-1:0] r_res_real;
   logic [CPLX_WIDTH-1:0] r_res_imag;

   // ---------------------------------------------------------------- operand unpack
   logic [REAL_WIDTH-1:0] w_a_re [NUM_REQ];
   logic [IMGN_WIDTH-1:0] w_a_im [NUM_REQ];
   logic [REAL_WIDTH-1:0] w_b_re [NUM_REQ];
   logic [IMGN_WIDTH-1:0] w_b_im [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_a_re[gi] = i_req_a_real[gi*REAL_WIDTH +: REAL_WIDTH];
         assign w_a_im[gi] = i_req_a_imag[gi*IMGN_WIDTH +: IMGN_WIDTH];
         assign w_b_re[gi] = i_req_b_real[gi*REAL_WIDTH +: REAL_WIDTH];
         assign w_b_im[gi] = i_req_b_imag[gi*IMGN_WIDTH +: IMGN_WIDTH];
      end
   endgenerate

   // ---------------------------------------------------------------- arbitration
   logic                w_found;
   logic [ID_WIDTH-1:0] w_gnt_id;
   logic                w_issue;
   logic [ID_WIDTH-1:0] w_rr_next;

   // Scan rr_ptr, rr_ptr+1, ... mod NUM_REQ; first valid requester wins.
   always_comb begin
      int v_idx;
      v_idx    = 0;
      w_found  = 1'b0;
      w_gnt_id = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
         if (!w_found && i_req_valid[v_idx]) begin
            w_found  = 1'b1;
            w_gnt_id = ID_WIDTH'(v_idx);
         end
      end
   end

   // Gating with i_rst_n keeps the grant and operands at zero while reset is
   // held, without waiting for a clock edge.
   assign w_issue   = w_found && (r_credits != '0) && i_rst_n;
   assign w_rr_next = ID_WIDTH'((int'(w_gnt_id) + 1) % NUM_REQ);

   always_comb begin
      o_req_ready = '0;
      if (w_issue) o_req_ready[w_gnt_id] = 1'b1;
   end

   assign o_mult_a_real = w_issue ? w_a_re[w_gnt_id] : '0;
   assign o_mult_a_imag = w_issue ? w_a_im[w_gnt_id] : '0;
   assign o_mult_b_real = w_issue ? w_b_re[w_gnt_id] : '0;
   assign o_mult_b_imag = w_issue ? w_b_im[w_gnt_id] : '0;

   // ---------------------------------------------------------------- FIFO control
   logic                  w_push;
   logic                  w_pop;
   logic [CNT_W-1:0]      w_cnt_after_pop;
   logic [CNT_W-1:0]      w_count_next;
   logic [PTR_W-1:0]      w_rd_ptr_next;
   logic                  w_res_valid_next;
   logic [ID_WIDTH-1:0]   w_res_id_next;
   logic [CPLX_WIDTH-1:0] w_res_real_next;
   logic [CPLX_WIDTH-1:0] w_res_imag_next;

   assign w_push          = r_tag_vld[MULT_LATENCY-1];
   assign w_pop           = r_res_valid && i_res_ready;
   assign w_cnt_after_pop = r_count - CNT_W'(w_pop);
   assign w_count_next    = w_cnt_after_pop + CNT_W'(w_push);
   assign w_rd_ptr_next   = r_rd_ptr + PTR_W'(w_pop);

   // Next head for the registered outputs. If the FIFO would otherwise be
   // empty after this pop, the entry being written now becomes the head, so
   // it is forwarded straight from the multiplier.
   always_comb begin
      w_res_valid_next = (w_count_next != '0);
      w_res_id_next    = '0;
      w_res_real_next  = '0;
      w_res_imag_next  = '0;
      if (w_count_next != '0) begin
         if (w_cnt_after_pop == '0) begin
            w_res_id_next   = r_tag_id[MULT_LATENCY-1];
            w_res_real_next = i_mult_res_real;
            w_res_imag_next = i_mult_res_imag;
         end else begin
            w_res_id_next   = r_mem_id[w_rd_ptr_next];
            w_res_real_next = r_mem_real[w_rd_ptr_next];
            w_res_imag_next = r_mem_imag[w_rd_ptr_next];
         end
      end
   end

   // ---------------------------------------------------------------- sequential
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr_ptr    <= '0;
         r_credits   <= CNT_W'(FIFO_DEPTH);
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_res_valid <= 1'b0;
         r_res_id    <= '0;
         r_res_real  <= '0;
         r_res_imag  <= '0;
         for (int s = 0; s < MULT_LATENCY; s++) begin
            r_tag_vld[s] <= 1'b0;
            r_tag_id[s]  <= '0;
         end
      end else begin
         if (w_issue) r_rr_ptr <= w_rr_next;

         // Credits cover results in flight plus results held in the FIFO.
         if (w_issue && !w_pop)      r_credits <= r_credits - CNT_W'(1);
         else if (!w_issue && w_pop) r_credits <= r_credits + CNT_W'(1);

         // Tag pipe shifts every cycle; the multiplier never stalls.
         r_tag_vld[0] <= w_issue;
         r_tag_id[0]  <= w_gnt_id;
         for (int s = 1; s < MULT_LATENCY; s++) begin
            r_tag_vld[s] <= r_tag_vld[s-1];
            r_tag_id[s]  <= r_tag_id[s-1];
         end

         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         r_rd_ptr    <= w_rd_ptr_next;
         r_count     <= w_count_next;
         r_res_valid <= w_res_valid_next;
         r_res_id    <= w_res_id_next;
         r_res_real  <= w_res_real_next;
         r_res_imag  <= w_res_imag_next;
      end
   end

   // Storage is not reset; contents are only meaningful below r_count.
   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_mem_id[r_wr_ptr]   <= r_tag_id[MULT_LATENCY-1];
         r_mem_real[r_wr_ptr] <= i_mult_res_real;
         r_mem_imag[r_wr_ptr] <= i_mult_res_imag;
      end
   end

   assign o_res_valid = r_res_valid;
   assign o_res_id    = r_res_id;
   assign o_res_real  = r_res_real;
   assign o_res_imag  = r_res_imag;

   // A capture into a full FIFO without a simultaneous pop means the credit
   // accounting is broken.
   a_no_overflow: assert property (@(posedge i_clock) disable iff (!i_rst_n)
      !(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));

endmodule
